// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle for both sides of stream_fifo: producer side (i_*) and consumer side (o_*).
interface stream_fifo_if #(
  parameter int width = 1
);
  logic             i_valid;
  logic             i_ready;
  logic [width-1:0] i;
  logic             o_valid;
  logic             o_ready;
  logic [width-1:0] o;

  // Environment view: drives the producer side and the consumer's ready.
  modport master (
    output i_valid, i, o_ready,
    input  i_ready, o_valid, o
  );

  // FIFO view.
  modport slave (
    input  i_valid, i, o_ready,
    output i_ready, o_valid, o
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides and a fill-level output.
// Pointers carry an extra wrap bit so full and empty are distinguishable without a counter.
module stream_fifo #(
  parameter int width = 1,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  stream_fifo_if.slave             bus,
  output logic [$clog2(depth):0]   level
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = 1;

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);

  // i_ready comes only from stored state, so a pop never opens a slot in the same cycle.
  assign push = bus.i_valid && !full;
  assign pop  = !empty && bus.o_ready;

  assign bus.i_ready = !full;
  assign bus.o_valid = !empty;
  assign bus.o       = empty ? '0 : mem[rd_ptr[aw-1:0]];
  assign level       = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
    end
  end

  // Storage is data only and deliberately carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[aw-1:0]] <= bus.i;
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Directed and randomized bench for stream_fifo (width=8, depth=4) against a queue model.
module tb_stream_fifo;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(D):0] level;

  stream_fifo_if #(.width(W)) bus ();

  stream_fifo #(.width(W), .depth(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .level (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".o_valid"}, 32'(bus.o_valid), 32'(q.size() != 0));
    chk({tag, ".o"},       32'(bus.o),       (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".i_ready"}, 32'(bus.i_ready), 32'(q.size() < D));
    chk({tag, ".level"},   32'(level),       32'(q.size()));
  endtask

  // One clock: drive inputs, check outputs against the model, then advance both.
  task automatic cycle(input string tag, input logic iv, input logic [W-1:0] din,
                       input logic ordy, input logic fl);
    bit do_push, do_pop;
    bus.i_valid = iv;
    bus.i       = din;
    bus.o_ready = ordy;
    flush       = fl;
    #1;
    check_state(tag);
    do_push = iv && (q.size() < D);
    do_pop  = ordy && (q.size() != 0);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(din);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] pat [4];
    bus.i_valid = 1'b0;
    bus.i       = '0;
    bus.o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T2 fill
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int k = 0; k < 4; k++) cycle("fill", 1'b1, pat[k], 1'b0, 1'b0);
    cycle("full_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // T3 full with simultaneous pop: 0x55 waits a cycle
    cycle("full_pop", 1'b1, 8'h55, 1'b1, 1'b0);
    cycle("full_retry", 1'b1, 8'h55, 1'b0, 1'b0);
    cycle("full_after", 1'b0, 8'h00, 1'b0, 1'b0);

    // T5 drain to empty, then single push
    for (int k = 0; k < 5; k++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("empty", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("empty_push", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("empty_again", 1'b0, 8'h00, 1'b0, 1'b0);

    // T4 streaming 0..19
    for (int k = 0; k < 20; k++) cycle("stream", 1'b1, 8'(k), 1'b1, 1'b0);
    cycle("stream_tail", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("stream_end", 1'b0, 8'h00, 1'b0, 1'b0);

    // T6 flush with concurrent push and pop
    for (int k = 0; k < 3; k++) cycle("pre_flush", 1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0);
    cycle("flush", 1'b1, 8'hEE, 1'b1, 1'b1);
    cycle("post_flush", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("post_flush2", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("post_flush3", 1'b0, 8'h00, 1'b0, 1'b0);

    // T1 asynchronous reset mid-stream at level 3
    for (int k = 0; k < 2; k++) cycle("pre_reset", 1'b1, 8'h70 + 8'(k), 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    #2;
    chk("pre_reset.level", 32'(level), 32'd3);
    rst_n = 1'b0;
    q.delete();
    #1;
    check_state("async_reset");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("after_reset", 1'b1, 8'h5A, 1'b0, 1'b0);
    cycle("after_reset2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic across many wraps
    for (int k = 0; k < 400; k++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end
    cycle("rand_end", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
